// File: rtl/div_pkg.sv
// Shared encodings for the sequential RV32M divider: funct3 op codes, FSM states
// and the iteration-counter width helper.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_adder.sv
// Ripple-carry adder shared with the ALU add path; the divider uses it as its
// trial subtractor (b inverted, cin=1).
module Adder #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < n; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU: magnitude division over
// N trial subtractions, then a single sign fix-up cycle.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = cnt_width(N);
  localparam logic [N-1:0] ONE = N'(1);

  div_state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [N-1:0]  q;
  logic [N:0]    r;
  logic [N-1:0]  d;
  logic [1:0]    op_r;
  logic          neg_q;
  logic          neg_r;

  logic [N:0]    rs;
  logic [N:0]    diff;
  logic          no_borrow;
  logic          r_msb_unused;

  logic signed [N-1:0] dividend_s;
  logic signed [N-1:0] divisor_s;
  logic                signed_op;
  logic                div_zero;

  function automatic logic [N-1:0] neg2c(input logic [N-1:0] x);
    return ~x + ONE;
  endfunction

  // MIN maps to 2^(N-1) read as unsigned, which keeps MIN/-1 on the normal path.
  function automatic logic [N-1:0] mag(input logic signed [N-1:0] x);
    return x[N-1] ? neg2c(x) : x;
  endfunction

  assign dividend_s   = dividend;
  assign divisor_s    = divisor;
  assign signed_op    = ~op[0];
  assign div_zero     = (divisor == '0);
  assign rs           = {r[N-1:0], q[N-1]};
  assign r_msb_unused = r[N];

  Adder #(.n(N+1)) u_trial_sub (
    .a    (rs),
    .b    (~{1'b0, d}),
    .cin  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start) state_nxt = div_zero ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      q      <= '0;
      r      <= '0;
      d      <= '0;
      op_r   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_r  <= op;
          cnt   <= CW'(N-1);
          r     <= '0;
          q     <= signed_op ? mag(dividend_s) : dividend;
          d     <= signed_op ? mag(divisor_s)  : divisor;
          neg_q <= signed_op & (dividend[N-1] ^ divisor[N-1]);
          neg_r <= signed_op & dividend[N-1];
          // Divide by zero skips CALC/FIX; RISC-V defines the result directly.
          if (div_zero) result <= op[1] ? dividend : '1;
        end
        CALC: begin
          q   <= {q[N-2:0], no_borrow};
          r   <= no_borrow ? diff : rs;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          if (op_r[1]) result <= neg_r ? neg2c(r[N-1:0]) : r[N-1:0];
          else         result <= neg_q ? neg2c(q) : q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized check of seq_divider against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  seq_divider #(.N(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V division semantics from plain 64-bit arithmetic (C-style truncation).
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] qv, rv;
    if (b == 32'd0) begin
      qv = 32'hFFFF_FFFF;
      rv = a;
    end else if (!o[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qv = 32'(sa / sb);
      rv = 32'(sa % sb);
    end else begin
      qv = a / b;
      rv = a % b;
    end
    return o[1] ? rv : qv;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit pulse, output logic [31:0] res, output int lat, output bit busy_ok);
    @(posedge clk); #1;
    start = 1'b1; op = o; dividend = a; divisor = b;
    lat = -1; busy_ok = 1'b1; res = 'x;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (pulse && (cyc == 5 || cyc == 33)) begin
        start = 1'b1; op = ~o; dividend = ~a; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = cyc;
        res = result;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit pulse, input bit full);
    logic [31:0] res;
    int lat;
    bit busy_ok;
    run_op(o, a, b, pulse, res, lat, busy_ok);
    check({tag, " result"}, res, exp);
    check({tag, " latency"}, 32'(lat), (b == 32'd0) ? 32'd1 : 32'd34);
    if (full) begin
      check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
      @(posedge clk); #1;
      check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
      check({tag, " idle done"}, {31'd0, done}, 32'd0);
      repeat (3) @(posedge clk);
      #1 check({tag, " held"}, result, exp);
    end
  endtask

  initial begin
    int seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b1;

    do_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
    do_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b1);
    do_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b1);
    do_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b1);
    do_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b1);
    do_op("divu 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    do_op("rem 5/0", 2'b10, 32'd5, 32'd0, 32'd5, 1'b0, 1'b1);
    do_op("div min/-1", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
    do_op("rem min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    do_op("divu max/min", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 1'b0, 1'b1);
    do_op("remu max/min", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    do_op("ignored start", 2'b01, 32'd1000, 32'd9, 32'd111, 1'b1, 1'b1);

    // Abort mid-CALC with an asynchronous reset.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort result", result, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("abort no done", 32'(seen), 32'd0);
    do_op("after abort", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      do_op($sformatf("rand%0d op%0d %h/%h", i, ro, ra, rb), ro, ra, rb, model(ro, ra, rb), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
